// File: rtl/rs_pkg.sv
// RS(15,11) shared definitions over GF(2^8).
// Used by both the encoder and decoder wrappers.
package rs_pkg;

  localparam int N     = 15;
  localparam int K     = 11;
  localparam int SYM_W = 8;

  localparam logic [8:0]       PRIM_POLY = 9'h11D;
  localparam logic [SYM_W-1:0] ALPHA     = 8'h02;

  // generator roots alpha^0..alpha^3, one per syndrome
  localparam logic [3:0][SYM_W-1:0] ROOTS =
    {8'h08, 8'h04, 8'h02, 8'h01};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYND,
    S_CHECK,
    S_SEARCH,
    S_CORRECT,
    S_FINISH
  } state_e;

  // shift-and-add multiply, reduced mod PRIM_POLY
  function automatic logic [SYM_W-1:0] gf_mul(
    input logic [SYM_W-1:0] a,
    input logic [SYM_W-1:0] b
  );
    logic [SYM_W-1:0] p;
    logic [SYM_W-1:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) p = p ^ t;
      if (t[SYM_W-1])
        t = {t[SYM_W-2:0], 1'b0} ^ PRIM_POLY[SYM_W-1:0];
      else
        t = {t[SYM_W-2:0], 1'b0};
    end
    return p;
  endfunction

endpackage

// File: rtl/rs_decode_wrapper_syndrome.sv
// Four Horner accumulators, one symbol per cycle,
// highest-degree coefficient first.
module rs_syndrome
  import rs_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [SYM_W-1:0] sym,
  output logic [SYM_W-1:0] s0,
  output logic [SYM_W-1:0] s1,
  output logic [SYM_W-1:0] s2,
  output logic [SYM_W-1:0] s3
);

  logic [3:0][SYM_W-1:0] s_q;

  // Sj <= Sj * alpha^j + sym
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
    end else if (clr) begin
      s_q <= '0;
    end else if (en) begin
      for (int j = 0; j < 4; j++)
        s_q[j] <= gf_mul(s_q[j], ROOTS[j]) ^ sym;
    end
  end

  assign s0 = s_q[0];
  assign s1 = s_q[1];
  assign s2 = s_q[2];
  assign s3 = s_q[3];

endmodule

// File: rtl/rs_decode_wrapper.sv
// RS(15,11) decoder: serial syndromes, sequential
// single-symbol locator search, in-place correction.
module rs_decode_wrapper
  import rs_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clrn,
  input  logic               decode_en,
  input  logic [8*N-1:0]     datain,
  output logic [8*K-1:0]     decoded_data,
  output logic               valid,
  output logic               ready,
  output logic               err_detected,
  output logic               err_corrected,
  output logic               err_uncorrectable,
  output logic [3:0]         err_pos
);

  state_e state_q, state_d;

  logic [SYM_W-1:0] cw_q [N];
  logic [3:0]       cnt_q;
  logic [3:0]       pos_q;
  logic [3:0]       loc_q;
  logic [SYM_W-1:0] x_q;
  logic             found_q;

  logic [8*K-1:0]   data_q;
  logic             valid_q;
  logic             ready_q;
  logic             det_q;
  logic             cor_q;
  logic             unc_q;
  logic [3:0]       epos_q;

  logic [SYM_W-1:0] s0, s1, s2, s3;
  logic             accept;
  logic             synd_zero;
  logic             match;

  assign accept = (state_q == S_IDLE)
                & ready_q & decode_en;

  assign synd_zero = ~|{s0, s1, s2, s3};

  // X is a candidate locator when S(j+1) = Sj * X
  assign match = (s0 != '0)
               && (s1 == gf_mul(s0, x_q))
               && (s2 == gf_mul(s1, x_q))
               && (s3 == gf_mul(s2, x_q));

  rs_syndrome u_synd (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept | ~clrn),
    .en    (state_q == S_SYND),
    .sym   (cw_q[cnt_q]),
    .s0    (s0),
    .s1    (s1),
    .s2    (s2),
    .s3    (s3)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state_q <= S_IDLE;
    else if (!clrn) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (accept) state_d = S_SYND;
      S_SYND:    if (cnt_q == 4'd14)
                   state_d = S_CHECK;
      S_CHECK:   state_d = synd_zero ? S_FINISH
                                     : S_SEARCH;
      S_SEARCH:  if (pos_q == 4'd0)
                   state_d = S_CORRECT;
      S_CORRECT: state_d = S_FINISH;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // codeword buffer, symbol counter and locator search
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) cw_q[i] <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      loc_q   <= '0;
      x_q     <= '0;
      found_q <= 1'b0;
    end else if (!clrn) begin
      for (int i = 0; i < N; i++) cw_q[i] <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      loc_q   <= '0;
      x_q     <= '0;
      found_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            for (int i = 0; i < N; i++)
              cw_q[i] <= datain[8*i +: 8];
            cnt_q <= '0;
          end
        end
        S_SYND: begin
          cnt_q <= cnt_q + 4'd1;
        end
        S_CHECK: begin
          x_q     <= 8'h01;
          pos_q   <= 4'd14;
          found_q <= 1'b0;
        end
        S_SEARCH: begin
          if (match && !found_q) begin
            found_q <= 1'b1;
            loc_q   <= pos_q;
          end
          x_q   <= gf_mul(x_q, ALPHA);
          pos_q <= pos_q - 4'd1;
        end
        S_CORRECT: begin
          if (found_q)
            cw_q[loc_q] <= cw_q[loc_q] ^ s0;
        end
        default: ;
      endcase
    end
  end

  // output and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      det_q   <= 1'b0;
      cor_q   <= 1'b0;
      unc_q   <= 1'b0;
      epos_q  <= '0;
    end else if (!clrn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      det_q   <= 1'b0;
      cor_q   <= 1'b0;
      unc_q   <= 1'b0;
      epos_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            det_q   <= 1'b0;
            cor_q   <= 1'b0;
            unc_q   <= 1'b0;
            epos_q  <= '0;
          end
        end
        S_CHECK: begin
          if (!synd_zero) det_q <= 1'b1;
        end
        S_CORRECT: begin
          if (found_q) begin
            cor_q  <= 1'b1;
            epos_q <= loc_q;
          end else begin
            unc_q  <= 1'b1;
          end
        end
        S_FINISH: begin
          for (int k = 0; k < K; k++)
            data_q[8*k +: 8] <= cw_q[k];
          valid_q <= 1'b1;
          ready_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign decoded_data      = data_q;
  assign valid             = valid_q;
  assign ready             = ready_q;
  assign err_detected      = det_q;
  assign err_corrected     = cor_q;
  assign err_uncorrectable = unc_q;
  assign err_pos           = epos_q;

endmodule
